// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit signal bundle: stage addresses and controls in,
// stall/flush/forward selects out. master = pipeline side, slave = hazard unit.
interface hazard_unit_sb_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5
);
   logic [NUM_SRC*REG_AW-1:0] RsD;
   logic [NUM_SRC*REG_AW-1:0] RsE;
   logic [REG_AW-1:0]         RdD;
   logic                      LongOpD;
   logic [REG_AW-1:0]         RdE;
   logic                      ResultSrcE0;
   logic                      LongIssueE;
   logic                      PCSrcE;
   logic [REG_AW-1:0]         RdM;
   logic                      RegWriteM;
   logic [REG_AW-1:0]         RdW;
   logic                      RegWriteW;
   logic                      LongDoneValid;
   logic [REG_AW-1:0]         LongDoneRd;
   logic                      StallF;
   logic                      StallD;
   logic                      FlushD;
   logic                      FlushE;
   logic [2*NUM_SRC-1:0]      ForwardE;
   logic                      LongBusy;

   modport master (
      output RsD, RsE, RdD, LongOpD, RdE, ResultSrcE0, LongIssueE, PCSrcE,
             RdM, RegWriteM, RdW, RegWriteW, LongDoneValid, LongDoneRd,
      input  StallF, StallD, FlushD, FlushE, ForwardE, LongBusy
   );

   modport slave (
      input  RsD, RsE, RdD, LongOpD, RdE, ResultSrcE0, LongIssueE, PCSrcE,
             RdM, RegWriteM, RdW, RegWriteW, LongDoneValid, LongDoneRd,
      output StallF, StallD, FlushD, FlushE, ForwardE, LongBusy
   );
endinterface

// File: rtl/hazard_unit_sb.sv
// 5-stage pipeline hazard unit: E-stage forwarding, load-use / branch handling,
// and a pending-register scoreboard for outstanding long-latency (mul/div) ops.
module hazard_unit_sb #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   hazard_unit_sb_if.slave hz
);
   localparam int NUM_REGS = 2**REG_AW;

   logic [NUM_REGS-1:0] r_pending;
   logic [CNT_W-1:0]    r_count;
   logic                r_long_busy;

   logic [NUM_REGS-1:0] w_pend_eff;
   logic [NUM_REGS-1:0] w_pending_next;
   logic [2*NUM_SRC-1:0] w_fwd;
   logic [NUM_SRC-1:0]  w_lw_hit;
   logic [NUM_SRC-1:0]  w_raw_hit;
   logic                w_lw_stall;
   logic                w_raw_stall;
   logic                w_waw_stall;
   logic                w_full_stall;
   logic                w_hz_stall;
   logic [CNT_W:0]      w_cnt_issue;
   logic [CNT_W:0]      w_full_thr;
   logic [CNT_W:0]      w_cnt_tmp;
   logic [CNT_W-1:0]    w_count_next;

   // A completing op is already invisible to D: the RF is write-first.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_x0
            assign w_pend_eff[gi]     = 1'b0;
            assign w_pending_next[gi] = 1'b0;
         end else begin : g_rn
            logic w_set;
            logic w_clr;
            assign w_set = hz.LongIssueE && (hz.RdE == REG_AW'(gi));
            assign w_clr = hz.LongDoneValid && (hz.LongDoneRd == REG_AW'(gi));
            assign w_pend_eff[gi]     = r_pending[gi] & ~w_clr;
            assign w_pending_next[gi] = w_set | (r_pending[gi] & ~w_clr);
         end
      end

      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [REG_AW-1:0] w_rs_e;
         logic [REG_AW-1:0] w_rs_d;
         logic              w_rs_d_nz;
         assign w_rs_e    = hz.RsE[gi*REG_AW +: REG_AW];
         assign w_rs_d    = hz.RsD[gi*REG_AW +: REG_AW];
         assign w_rs_d_nz = (w_rs_d != '0);

         // M has priority over W: it holds the younger value.
         always_comb begin
            w_fwd[2*gi +: 2] = 2'b00;
            if (w_rs_e != '0) begin
               if (hz.RegWriteM && (w_rs_e == hz.RdM))
                  w_fwd[2*gi +: 2] = 2'b01;
               else if (hz.RegWriteW && (w_rs_e == hz.RdW))
                  w_fwd[2*gi +: 2] = 2'b10;
            end
         end

         assign w_lw_hit[gi]  = hz.ResultSrcE0 && w_rs_d_nz && (w_rs_d == hz.RdE);
         assign w_raw_hit[gi] = w_pend_eff[w_rs_d] ||
                                (hz.LongIssueE && w_rs_d_nz && (w_rs_d == hz.RdE));
      end
   endgenerate

   assign w_lw_stall  = |w_lw_hit;
   assign w_raw_stall = |w_raw_hit;
   assign w_waw_stall = (hz.RdD != '0) &&
                        (w_pend_eff[hz.RdD] || (hz.LongIssueE && (hz.RdD == hz.RdE)));

   // Projected occupancy compared without subtraction so it cannot go negative.
   assign w_cnt_issue  = {1'b0, r_count} + {{CNT_W{1'b0}}, hz.LongIssueE};
   assign w_full_thr   = (CNT_W+1)'(DEPTH) + {{CNT_W{1'b0}}, hz.LongDoneValid};
   assign w_full_stall = hz.LongOpD && (w_cnt_issue >= w_full_thr);

   assign w_hz_stall = w_lw_stall | w_raw_stall | w_waw_stall | w_full_stall;

   always_comb begin
      w_cnt_tmp = w_cnt_issue;
      if (hz.LongDoneValid && (w_cnt_issue != '0))
         w_cnt_tmp = w_cnt_issue - (CNT_W+1)'(1);
      if (w_cnt_tmp > (CNT_W+1)'(DEPTH))
         w_cnt_tmp = (CNT_W+1)'(DEPTH);
      w_count_next = w_cnt_tmp[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending   <= '0;
         r_count     <= '0;
         r_long_busy <= 1'b0;
      end else begin
         r_pending   <= w_pending_next;
         r_count     <= w_count_next;
         r_long_busy <= (w_count_next != '0);
      end
   end

   // A taken branch kills the D instruction, so its stall is void.
   assign hz.StallF   = w_hz_stall & ~hz.PCSrcE;
   assign hz.StallD   = w_hz_stall & ~hz.PCSrcE;
   assign hz.FlushD   = hz.PCSrcE;
   assign hz.FlushE   = hz.PCSrcE | w_hz_stall;
   assign hz.ForwardE = w_fwd;
   assign hz.LongBusy = r_long_busy;
endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Generates E-stage operand forwarding selects for NUM_SRC source operands.
- Detects load-use stalls and branch flushes.
- Adds a registered scoreboard that tracks up to DEPTH outstanding long-latency ops (mul/div) and stalls Decode on RAW/WAW hazards against them and on scoreboard-full.

Parameters:
- NUM_SRC, 2, number of source operands per instruction.
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- DEPTH, 2, maximum outstanding long ops (1..NUM_REGS-1).
- CNT_W, 2, width of the outstanding counter; must hold DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RsD  in  NUM_SRC*REG_AW  D-stage source addresses; src i at bits [i*REG_AW +: REG_AW].
- RsE  in  NUM_SRC*REG_AW  E-stage source addresses, same packing.
- RdD  in  REG_AW  D-stage destination.
- LongOpD  in  1  D instruction is a long op.
- RdE  in  REG_AW  E-stage destination.
- ResultSrcE0  in  1  E instruction is a load.
- LongIssueE  in  1  E instruction is a long op being dispatched to the long unit this cycle.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- RdM  in  REG_AW  M-stage destination.
- RegWriteM  in  1  M instruction writes the register file.
- RdW  in  REG_AW  W-stage destination.
- RegWriteW  in  1  W instruction writes the register file.
- LongDoneValid  in  1  long unit writes its result to the RF this cycle.
- LongDoneRd  in  REG_AW  destination of the completing long op.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  clear IF/ID register.
- FlushE  out  1  clear ID/EX register.
- ForwardE  out  2*NUM_SRC  per-source select at [2i +: 2]: 00 RF, 01 M, 10 W.
- LongBusy  out  1  registered; high when the outstanding count is non-zero.

Behaviour:
- State: Pending[NUM_REGS-1:0] and Count[CNT_W-1:0], both updated on the rising edge of clk.
- Async reset (rst_n low): Pending=0, Count=0, LongBusy=0. Reset mid-operation discards all tracked ops; the long unit is reset by the same signal.
- Forwarding (combinational), per source i, with r = RsE[i]:
  - 01 if r==RdM, RegWriteM and r!=0.
  - else 10 if r==RdW, RegWriteW and r!=0.
  - else 00.
  - M has priority over W.
- Define PendEff[r] = Pending[r] & ~(LongDoneValid & LongDoneRd==r). A completion is treated as visible in the same cycle; the RF is write-first.
- Stall conditions (combinational), each qualified by register address != 0:
  - lwStall: ResultSrcE0 and any RsD[i]==RdE.
  - rawStall: any PendEff[RsD[i]], or (LongIssueE and any RsD[i]==RdE).
  - wawStall: PendEff[RdD], or (LongIssueE and RdD==RdE). Both only when RdD != 0.
  - fullStall: LongOpD and (Count + LongIssueE - LongDoneValid) >= DEPTH.
- hzStall = lwStall | rawStall | wawStall | fullStall.
- Outputs:
  - StallF = StallD = hzStall & ~PCSrcE. A taken branch kills the D instruction, so its stall is void.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | hzStall. A bubble is inserted on a stall.
- Scoreboard update per cycle:
  - Set: if LongIssueE and RdE!=0, set Pending[RdE]. This applies even when PCSrcE is high, because the E instruction is not killed.
  - Clear: if LongDoneValid, clear Pending[LongDoneRd].
  - Same register set and cleared in one cycle: set wins. This cannot legally occur, since WAW stalls prevent it.
  - Count += LongIssueE - LongDoneValid. Count is tracked for rd=x0 long ops too, so that slots are accounted.
  - Count saturates at 0 and at DEPTH. A LongDoneValid with Count==0 is ignored (no underflow). LongIssueE with Count==DEPTH is a protocol error and must not occur, since fullStall prevents it.
- LongBusy = (Count != 0), registered.
- x0 is never pending; it is never forwarded and never stalled on.
- Latency: forwarding and stalls are combinational from inputs and state. A scoreboard set is visible to D one cycle after LongIssueE.

Test Plan:
- Forwarding priority: RsE={5,5}, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardE=0101. Drop RegWriteM -> 1010. RsE=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, RsD[1]=7 -> StallF=StallD=FlushE=1 for one cycle. With PCSrcE=1 in the same cycle -> StallF=StallD=0, FlushD=FlushE=1.
- Long RAW: LongIssueE=1, RdE=9; next cycles RsD[0]=9 -> stall held until the LongDoneValid cycle with LongDoneRd=9, where stall=0 in that cycle. Pending[9]=0 and LongBusy=0 afterwards.
- WAW: Pending[3]=1, RdD=3 -> stall. RdD=0 with Pending[3]=1 -> no stall.
- Full: DEPTH=2, two issues to rd 4 and 6 -> Count=2. LongOpD=1 -> stall. Same cycle LongDoneValid for rd 4 -> no stall.
- Reset mid-op: Count=2 with Pending bits set, pulse rst_n low -> Pending=0, LongBusy=0, no stall on the previously pending registers.
